// File: rtl/clk_en_divider.sv
// -----------------------------------------------------------------------------
// clk_en_divider
//
// Programmable divide-by-N stage. Produces a one-cycle enable strobe (tick)
// and a registered square wave (div_clk), both in the clk domain, so that
// downstream stages can use tick as a clock enable instead of a derived clock.
// The divisor may be changed at run time; while counting, a new divisor is
// held pending and applied at the next period boundary so no period is cut
// short or stretched.
//
// Ports:
//   clk       in   system clock, all logic on rising edge
//   reset     in   synchronous, active-high reset (dominates load and en)
//   en        in   count enable; 0 freezes phase and div_clk, forces tick low
//   load      in   one-cycle request to take div_val as the new divisor
//   div_val   in   requested divisor N (WIDTH bits); 0 and 1 clamp to 2
//   tick      out  one-cycle strobe in the last cycle of each period
//   div_clk   out  square wave: low for floor(N/2), high for ceil(N/2) cycles
//   phase     out  current counter value, 0..N-1
//   upd_pend  out  a new divisor has been captured but not yet applied
// -----------------------------------------------------------------------------
module clk_en_divider #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             tick,
  output logic             div_clk,
  output logic [WIDTH-1:0] phase,
  output logic             upd_pend
);

  // Divisors below 2 cannot produce a distinct terminal cycle, so force 2.
  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    if (x < WIDTH'(2)) begin
      r = WIDTH'(2);
    end else begin
      r = x;
    end
    return r;
  endfunction

  localparam logic [WIDTH-1:0] DEFAULT_DIV_C =
    (DEFAULT_DIV < 32'd2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] phase_r;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] pend_r;
  logic             upd_pend_r;
  logic             tick_r;
  logic             div_clk_r;

  logic [WIDTH-1:0] phase_s;
  logic [WIDTH-1:0] div_s;
  logic [WIDTH-1:0] pend_s;
  logic             upd_pend_s;
  logic             tick_s;
  logic             div_clk_s;
  logic [WIDTH-1:0] load_val_s;
  logic             terminal_s;

  // Next-state evaluation; outputs are derived from the next phase/divisor so
  // the registered tick and div_clk line up with the registered phase.
  always_comb begin
    load_val_s = clamp_div(div_val);
    // div_r >= 2 always, so div_r - 1 never underflows.
    terminal_s = (phase_r == (div_r - WIDTH'(1)));

    phase_s    = phase_r;
    div_s      = div_r;
    pend_s     = pend_r;
    upd_pend_s = upd_pend_r;
    tick_s     = 1'b0;
    div_clk_s  = div_clk_r;

    if (!en) begin
      if (load) begin
        // Frozen stage: nothing is mid-period, so restart with the new N now.
        div_s      = load_val_s;
        phase_s    = '0;
        div_clk_s  = 1'b0;
        upd_pend_s = 1'b0;
      end else begin
        phase_s    = phase_r;
        div_clk_s  = div_clk_r;
      end
    end else begin
      if (terminal_s) begin
        phase_s = '0;
        if (load) begin
          // Request arriving on the wrap itself is taken at this boundary.
          div_s      = load_val_s;
          upd_pend_s = 1'b0;
        end else if (upd_pend_r) begin
          div_s      = pend_r;
          upd_pend_s = 1'b0;
        end else begin
          div_s      = div_r;
        end
      end else begin
        phase_s = phase_r + WIDTH'(1);
        if (load) begin
          // Last request wins; apply point stays at the current wrap.
          pend_s     = load_val_s;
          upd_pend_s = 1'b1;
        end else begin
          pend_s     = pend_r;
        end
      end
      tick_s    = (phase_s == (div_s - WIDTH'(1)));
      div_clk_s = (phase_s >= (div_s >> 1));
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r    <= '0;
      div_r      <= DEFAULT_DIV_C;
      pend_r     <= '0;
      upd_pend_r <= 1'b0;
      tick_r     <= 1'b0;
      div_clk_r  <= 1'b0;
    end else begin
      phase_r    <= phase_s;
      div_r      <= div_s;
      pend_r     <= pend_s;
      upd_pend_r <= upd_pend_s;
      tick_r     <= tick_s;
      div_clk_r  <= div_clk_s;
    end
  end

  assign tick     = tick_r;
  assign div_clk  = div_clk_r;
  assign phase    = phase_r;
  assign upd_pend = upd_pend_r;

endmodule

// File: tb/tb_clk_en_divider.sv
// -----------------------------------------------------------------------------
// tb_clk_en_divider
//
// Directed, self-checking bench for clk_en_divider (WIDTH=8, DEFAULT_DIV=4).
// Each step drives the inputs for one clock cycle and pushes the hand-derived
// expected outputs for after that edge into a queue; after the edge the entry
// is popped and compared field by field.
// -----------------------------------------------------------------------------
module tb_clk_en_divider;

  typedef struct packed {
    logic [7:0] phase;
    logic       tick;
    logic       div_clk;
    logic       upd_pend;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [7:0] div_val;
  logic       tick;
  logic       div_clk;
  logic [7:0] phase;
  logic       upd_pend;

  exp_t exp_q[$];
  int   compared;
  int   mismatched;
  int   step_no;

  clk_en_divider #(
    .WIDTH       (8),
    .DEFAULT_DIV (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .div_val  (div_val),
    .tick     (tick),
    .div_clk  (div_clk),
    .phase    (phase),
    .upd_pend (upd_pend)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pop the oldest expectation and compare it with the current outputs.
  task automatic check_outputs();
    exp_t e;
    compared++;
    assert (exp_q.size() > 0) else begin
      mismatched++;
      $error("FAIL step%0d queue: observed empty scoreboard, expected an entry", step_no);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      assert (phase === e.phase) else begin
        mismatched++;
        $error("FAIL step%0d phase: observed %0d expected %0d", step_no, phase, e.phase);
      end
      compared++;
      assert (tick === e.tick) else begin
        mismatched++;
        $error("FAIL step%0d tick: observed %b expected %b", step_no, tick, e.tick);
      end
      compared++;
      assert (div_clk === e.div_clk) else begin
        mismatched++;
        $error("FAIL step%0d div_clk: observed %b expected %b", step_no, div_clk, e.div_clk);
      end
      compared++;
      assert (upd_pend === e.upd_pend) else begin
        mismatched++;
        $error("FAIL step%0d upd_pend: observed %b expected %b", step_no, upd_pend, e.upd_pend);
      end
    end
  endtask

  // Drive one cycle of stimulus, record what must appear after the edge.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [7:0] dv, input logic [7:0] ep,
                      input logic et, input logic ed, input logic eu);
    exp_t x;
    reset   = r;
    en      = e;
    load    = l;
    div_val = dv;
    x.phase    = ep;
    x.tick     = et;
    x.div_clk  = ed;
    x.upd_pend = eu;
    exp_q.push_back(x);
    step_no++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    step_no    = 0;
    reset      = 1'b1;
    en         = 1'b0;
    load       = 1'b0;
    div_val    = 8'd0;

    //     rst   en    load  dv     phase  tick  dclk  upd
    // Reset, including reset dominating en and load.
    step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'd9, 8'd0, 1'b0, 1'b0, 1'b0);

    // Default N=4: phase 0,1,2,3; tick at phase 3; div_clk 0,0,1,1.
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    // Freeze 3 cycles at phase 2, then tick one enabled cycle later.
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    // Freeze on the terminal phase: no repeated and no lost tick.
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 8'd3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Load 5 while counting: upd_pend for phases 1..3, old period completes.
    step(1'b0, 1'b1, 1'b1, 8'd5, 8'd1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b1);
    // N=5: low 2 cycles, high 3, tick every 5.
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd4, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);

    // Load 0 while frozen: clamps to 2, restarts at phase 0 immediately.
    step(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Back to N=4, then load 6 in the terminal cycle: no pending phase.
    step(1'b0, 1'b0, 1'b1, 8'd4, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'd6, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    // Load 7, then 3 while pending: 3 wins and is applied at the wrap.
    step(1'b0, 1'b1, 1'b1, 8'd7, 8'd1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'd3, 8'd2, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd4, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd5, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // N=4 with a pending 9, reset at phase 3: pending discarded, N=4 kept.
    step(1'b0, 1'b0, 1'b1, 8'd4, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'd9, 8'd2, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b1, 1'b1, 1'b0);

    // Every pushed expectation must have been consumed.
    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("FAIL drain: observed %0d leftover entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
